// File: rtl/toy_mem_if.sv
// Instruction/data bus bundle between the RISC_TOY core and its memory responder.
// The core drives requests (master); the memory returns read data and the error flag (slave).
interface toy_mem_if;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        DREQ;
  logic        DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        ERR;

  modport master (
    output IREQ, IADDR, DREQ, DRW, DADDR, DWDATA,
    input  INSTR, DRDATA, ERR
  );

  modport slave (
    input  IREQ, IADDR, DREQ, DRW, DADDR, DWDATA,
    output INSTR, DRDATA, ERR
  );
endinterface

// File: rtl/toy_mem_responder.sv
// Word-addressed memory for the RISC_TOY core: read-only instruction port and read/write
// data port over one shared array, each read path pipelined RD_LAT (1..4) edges deep.
module toy_mem_responder #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input logic      CLK,
  input logic      RSTN,
  toy_mem_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] i_idx, d_idx;
  logic          i_in_range, d_in_range;
  logic          i_rd, d_rd, d_wr;

  assign i_idx      = bus.IADDR[AW-1:0];
  assign d_idx      = bus.DADDR[AW-1:0];
  assign i_in_range = (bus.IADDR[29:AW] == '0);
  assign d_in_range = (bus.DADDR[29:AW] == '0);

  assign i_rd = bus.IREQ;
  assign d_rd = bus.DREQ & ~bus.DRW;
  assign d_wr = bus.DREQ & bus.DRW & d_in_range;

  // NOTE: the storage array has no reset branch; clearing 2^AW words would forbid RAM
  // inference, and its contents are defined to survive reset anyway.
  always_ff @(posedge CLK) begin
    if (RSTN && d_wr)
      mem[d_idx] <= bus.DWDATA;
  end

  // Bit s of *_vq marks stage s as holding a delivered-in-order result; *_vin is the set
  // of stages that load at the coming edge (stage 0 loads straight from the request).
  logic [RD_LAT-1:0] i_vq, i_vin;
  logic [RD_LAT-1:0] d_vq, d_vin;
  logic [31:0]       i_d [RD_LAT];
  logic [31:0]       d_d [RD_LAT];

  assign i_vin = (i_vq << 1) | RD_LAT'(i_rd);
  assign d_vin = (d_vq << 1) | RD_LAT'(d_rd);

  // NOTE: all state here uses non-blocking assignments so every stage samples the values
  // from before the edge; this also makes the array read return the pre-write word.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      i_vq <= '0;
      d_vq <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        i_d[s] <= '0;
        d_d[s] <= '0;
      end
    end else begin
      i_vq <= i_vin;
      d_vq <= d_vin;

      if (i_vin[0])
        i_d[0] <= i_in_range ? mem[i_idx] : 32'h0;
      if (d_vin[0])
        d_d[0] <= d_in_range ? mem[d_idx] : 32'h0;

      // A stage's data only moves when a valid entry arrives, so the last stage (the
      // output) holds its value indefinitely once the pipe drains.
      for (int s = 1; s < RD_LAT; s++) begin
        if (i_vin[s])
          i_d[s] <= i_d[s-1];
        if (d_vin[s])
          d_d[s] <= d_d[s-1];
      end
    end
  end

  logic err;

  always_ff @(posedge CLK) begin
    if (!RSTN)
      err <= 1'b0;
    else if ((i_rd && !i_in_range) || (bus.DREQ && !d_in_range))
      err <= 1'b1;
  end

  assign bus.INSTR  = i_d[RD_LAT-1];
  assign bus.DRDATA = d_d[RD_LAT-1];
  assign bus.ERR    = err;

endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench for toy_mem_responder: a vector table on an RD_LAT=1 instance, plus
// hand sequences for RD_LAT=3 streaming and RD_LAT=4 reset-while-in-flight.
module tb_toy_mem_responder;

  logic clk;
  logic rst_n;

  toy_mem_if bus1 ();
  toy_mem_if bus3 ();
  toy_mem_if bus4 ();

  toy_mem_responder #(.AW(10), .RD_LAT(1)) dut1 (.CLK(clk), .RSTN(rst_n), .bus(bus1));
  toy_mem_responder #(.AW(10), .RD_LAT(3)) dut3 (.CLK(clk), .RSTN(rst_n), .bus(bus3));
  toy_mem_responder #(.AW(10), .RD_LAT(4)) dut4 (.CLK(clk), .RSTN(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ireq;
    logic [29:0] iaddr;
    logic        dreq;
    logic        drw;
    logic [29:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] exp_instr;
    logic [31:0] exp_drdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus1.IREQ = 0; bus1.IADDR = '0; bus1.DREQ = 0; bus1.DRW = 0; bus1.DADDR = '0; bus1.DWDATA = '0;
    bus3.IREQ = 0; bus3.IADDR = '0; bus3.DREQ = 0; bus3.DRW = 0; bus3.DADDR = '0; bus3.DWDATA = '0;
    bus4.IREQ = 0; bus4.IADDR = '0; bus4.DREQ = 0; bus4.DRW = 0; bus4.DADDR = '0; bus4.DWDATA = '0;
  endtask

  initial begin
    //          ireq iaddr        dreq drw daddr          dwdata        instr         drdata        err
    vecs[0]  = '{1'b0, 30'h0,     1'b1, 1'b1, 30'h5,        32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 30'h0,     1'b1, 1'b0, 30'h5,        32'h0,        32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 30'h5,     1'b0, 1'b1, 30'h5,        32'h12345678, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 30'h5,     1'b1, 1'b0, 30'h5,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 30'h0,     1'b1, 1'b1, 30'h7,        32'h0000000F, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 30'h7,     1'b1, 1'b1, 30'h7,        32'hA5A5A5A5, 32'h0000000F, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 30'h7,     1'b1, 1'b0, 30'h7,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[7]  = '{1'b0, 30'h0,     1'b1, 1'b1, 30'h0,        32'hCAFE0000, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{1'b0, 30'h0,     1'b1, 1'b1, 30'h400,      32'hBAD0BAD0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
    vecs[9]  = '{1'b1, 30'h400,   1'b1, 1'b0, 30'h0,        32'h0,        32'h0,        32'hCAFE0000, 1'b1};
    vecs[10] = '{1'b0, 30'h0,     1'b1, 1'b0, 30'h400,      32'h0,        32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 30'h0,     1'b0, 1'b0, 30'h0,        32'h0,        32'hCAFE0000, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 30'h0,     1'b1, 1'b1, 30'h3FF,      32'h00000077, 32'hCAFE0000, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 30'h3FF,   1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,        32'h00000077, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 30'h0,     1'b1, 1'b0, 30'h3FF,      32'h0,        32'h00000077, 32'h00000077, 1'b1};

    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_instr1",  bus1.INSTR,  32'h0);
    check("rst_drdata1", bus1.DRDATA, 32'h0);
    check("rst_err1",    {31'h0, bus1.ERR}, 32'h0);
    check("rst_instr3",  bus3.INSTR,  32'h0);
    check("rst_drdata4", bus4.DRDATA, 32'h0);
    rst_n = 1'b1;

    // RD_LAT=1 vector table: each vector is visible at the negedge after its sampling edge.
    for (int i = 0; i < 15; i++) begin
      bus1.IREQ   = vecs[i].ireq;
      bus1.IADDR  = vecs[i].iaddr;
      bus1.DREQ   = vecs[i].dreq;
      bus1.DRW    = vecs[i].drw;
      bus1.DADDR  = vecs[i].daddr;
      bus1.DWDATA = vecs[i].dwdata;
      tick();
      check($sformatf("vec%0d_instr", i),  bus1.INSTR,  vecs[i].exp_instr);
      check($sformatf("vec%0d_drdata", i), bus1.DRDATA, vecs[i].exp_drdata);
      check($sformatf("vec%0d_err", i),    {31'h0, bus1.ERR}, {31'h0, vecs[i].exp_err});
    end

    // DREQ=0 with DRW=1 and junk write data must neither write nor disturb outputs.
    for (int i = 0; i < 10; i++) begin
      bus1.IREQ   = 1'b0;
      bus1.DREQ   = 1'b0;
      bus1.DRW    = 1'b1;
      bus1.DADDR  = (i % 2 == 0) ? 30'h5 : 30'h7;
      bus1.DWDATA = $urandom;
      tick();
      check($sformatf("idle%0d_instr", i),  bus1.INSTR,  32'h00000077);
      check($sformatf("idle%0d_drdata", i), bus1.DRDATA, 32'h00000077);
    end
    bus1.IREQ  = 1'b1; bus1.IADDR = 30'h5;
    bus1.DREQ  = 1'b1; bus1.DRW   = 1'b0; bus1.DADDR = 30'h7;
    tick();
    check("idle_keep5", bus1.INSTR,  32'hDEADBEEF);
    check("idle_keep7", bus1.DRDATA, 32'hA5A5A5A5);
    check("err_sticky", {31'h0, bus1.ERR}, 32'h1);
    idle_all();

    // RD_LAT=3: preload then stream three instruction reads back to back.
    bus3.DREQ = 1'b1; bus3.DRW = 1'b1;
    bus3.DADDR = 30'h0; bus3.DWDATA = 32'h11; tick();
    bus3.DADDR = 30'h1; bus3.DWDATA = 32'h22; tick();
    bus3.DADDR = 30'h2; bus3.DWDATA = 32'h33; tick();
    bus3.DREQ = 1'b0; bus3.DRW = 1'b0;
    bus3.IREQ = 1'b1; bus3.IADDR = 30'h0; tick();
    check("lat3_n0", bus3.INSTR, 32'h0);
    bus3.IADDR = 30'h1; tick();
    check("lat3_n1", bus3.INSTR, 32'h0);
    bus3.IADDR = 30'h2; tick();
    check("lat3_n2", bus3.INSTR, 32'h11);
    bus3.IREQ = 1'b0; bus3.IADDR = 30'h0; tick();
    check("lat3_n3", bus3.INSTR, 32'h22);
    tick();
    check("lat3_n4", bus3.INSTR, 32'h33);
    tick();
    check("lat3_hold", bus3.INSTR, 32'h33);

    // RD_LAT=4: reset lands one edge after a read is issued.
    bus4.DREQ = 1'b1; bus4.DRW = 1'b1; bus4.DADDR = 30'h9; bus4.DWDATA = 32'h99; tick();
    bus4.DADDR = 30'h2000_0000; bus4.DWDATA = 32'h1; tick();
    check("lat4_err_set", {31'h0, bus4.ERR}, 32'h1);
    bus4.DRW = 1'b0; bus4.DADDR = 30'h9; tick();
    rst_n = 1'b0;
    bus4.IREQ = 1'b1; bus4.IADDR = 30'h9;
    bus4.DRW = 1'b1; bus4.DWDATA = 32'hBAD; tick();
    check("lat4_rst_drdata", bus4.DRDATA, 32'h0);
    check("lat4_rst_instr",  bus4.INSTR,  32'h0);
    check("lat4_rst_err",    {31'h0, bus4.ERR}, 32'h0);
    rst_n = 1'b1;
    idle_all();
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("lat4_nolate%0d", i), bus4.DRDATA, 32'h0);
    end
    bus4.IREQ = 1'b1; bus4.IADDR = 30'h9;
    bus4.DREQ = 1'b1; bus4.DRW = 1'b0; bus4.DADDR = 30'h9; tick();
    idle_all();
    tick();
    tick();
    check("lat4_m2_drdata", bus4.DRDATA, 32'h0);
    tick();
    check("lat4_m3_drdata", bus4.DRDATA, 32'h99);
    check("lat4_m3_instr",  bus4.INSTR,  32'h99);
    check("lat4_m3_err",    {31'h0, bus4.ERR}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_mem_responder.md
Name: toy_mem_responder

Overview:
Word-addressed memory responder for the RISC_TOY core's instruction and data buses. It answers the core's requests on both buses.
- Instruction bus: IREQ/IADDR/INSTR, read-only.
- Data bus: DREQ/DRW/DADDR/DWDATA/DRDATA, read/write.
- One shared storage array with a configurable, pipelined read latency.
- Used as the core's memory in simulation and in the FPGA top level.

Parameters:
AW, 10, index width; storage depth is 2^AW 32-bit words.
RD_LAT, 1, read latency in clock edges, legal range 1..4.

Ports:
CLK  input  1  clock; all logic on rising edge.
RSTN  input  1  synchronous reset, active-low.
IREQ  input  1  instruction read request.
IADDR  input  30  instruction word address.
INSTR  output  32  instruction read data.
DREQ  input  1  data request.
DRW  input  1  data direction: 1 = write, 0 = read; ignored when DREQ=0.
DADDR  input  30  data word address.
DWDATA  input  32  data write value; ignored on reads.
DRDATA  output  32  data read data.
ERR  output  1  sticky out-of-range access flag.

Behaviour:
- Storage: array of 2^AW x 32. Contents are not cleared by reset and are undefined until written.
- Address decode:
  - Index = ADDR[AW-1:0].
  - An access is in range iff ADDR[29:AW]==0.
- Data write:
  - A DREQ=1, DRW=1 sample at edge N with an in-range address writes DWDATA at edge N.
  - DRDATA is not changed by a write.
- Reads (both ports, independently): a request sampled at edge N delivers data after edge N+RD_LAT-1.
  - RD_LAT=1: edge N reads the array into the output register, so data is visible in cycle N+1.
  - RD_LAT=k: k pipeline stages, each with data and a valid bit.
  - Back-to-back requests every cycle give one result per cycle, in order.
- Output hold: INSTR/DRDATA change only when a valid pipeline entry retires. When no request is in flight, the last delivered value holds indefinitely.
- Out-of-range accesses:
  - A read returns 32'h0 through the normal pipeline and latency.
  - A write is dropped, and the array is unchanged.
  - Either case sets ERR at that edge.
- ERR is sticky until reset. Simultaneous out-of-range on both ports sets it once; there is no other effect.
- Read/write collision (IREQ read of index X at the same edge as a data write of index X): read-first, so INSTR returns the old value. A read at any later edge returns the new value.
- Ordering on the data port: a read sampled at the edge after a write to the same index returns the written value.
- Reset (RSTN=0 at an edge):
  - INSTR=0, DRDATA=0, ERR=0, all pipeline valid bits=0.
  - In-flight reads are discarded and never delivered.
  - Requests and writes sampled while RSTN=0 are ignored, and the array is unchanged.
  - After RSTN rises, the first request is handled normally, with full latency.
- The bus has no backpressure: the responder accepts every request on every cycle.

Test Plan:
- RD_LAT=1: write DADDR=5, DWDATA=32'hDEADBEEF at edge 1; read DADDR=5 at edge 2 -> DRDATA=32'hDEADBEEF in cycle 3 and held while DREQ=0.
- RD_LAT=3: IREQ every cycle to IADDR 0,1,2 after preloading 32'h11,32'h22,32'h33 -> INSTR shows 11,22,33 on consecutive cycles, starting after edge N+2.
- Collision: IADDR=7 read and DADDR=7 write of 32'hA5A5A5A5 at the same edge, old content 32'h0F -> INSTR=32'h0F; an IADDR=7 read the next edge -> 32'hA5A5A5A5.
- Out-of-range (AW=10): write DADDR=30'h400, then read DADDR=30'h400 and DADDR=0 -> write dropped (index 0 unchanged), read data 32'h0, ERR=1 and stays 1.
- Reset mid-flight, RD_LAT=4: issue a read, assert RSTN=0 at the next edge -> DRDATA=0, ERR=0, no late delivery; memory content from before reset is still readable afterwards.
- DREQ=0 with DRW=1 and arbitrary DWDATA for 10 cycles -> no array write and outputs unchanged.
